// File: rtl/shift_sequencer.sv
// Shift-instruction sequencer: decodes a shift operation, optionally waits for a
// memory operand, then steps the shifter through load, shift and write-back.
module shift_sequencer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] Shift_Op,
   input  logic       mem_ready,
   output logic [1:0] Shift_Amt,
   output logic       Shift_Src,
   output logic [2:0] Shift_Ctrl,
   output logic       mem_read,
   output logic       Reg_Wr,
   output logic       busy,
   output logic       done,
   output logic       illegal,
   output logic       timeout
);

   typedef enum logic [2:0] {IDLE, MEM_WAIT, LOAD, SHIFT, WRITE} state_t;
   typedef enum logic [2:0] {
      OP_SLL  = 3'b000, OP_SRL  = 3'b001, OP_SRA  = 3'b010, OP_SLLV = 3'b011,
      OP_SRAV = 3'b100, OP_SLLM = 3'b101, OP_BAD6 = 3'b110, OP_BAD7 = 3'b111
   } op_t;

   localparam logic [3:0] WAIT_LIMIT = 4'(MEM_TIMEOUT);

   state_t     state, state_next;
   op_t        op_q, op_next, op_in;
   logic [3:0] wait_cnt, cnt_next, cnt_inc;
   logic       illegal_q, illegal_next, timeout_q, timeout_next;
   logic [1:0] dec_amt;
   logic       dec_src;
   logic [2:0] dec_cmd;

   assign op_in   = op_t'(Shift_Op);
   assign cnt_inc = wait_cnt + 4'd1;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         op_q      <= OP_SLL;
         wait_cnt  <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_next;
         op_q      <= op_next;
         wait_cnt  <= cnt_next;
         illegal_q <= illegal_next;
         timeout_q <= timeout_next;
      end
   end

   // NOTE: every comb output gets a default first, so no path infers a latch.
   always_comb begin
      state_next   = state;
      op_next      = op_q;
      cnt_next     = wait_cnt;
      illegal_next = 1'b0;
      timeout_next = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (op_in == OP_BAD6 || op_in == OP_BAD7) begin
                  illegal_next = 1'b1;
               end else begin
                  op_next    = op_in;
                  cnt_next   = '0;
                  state_next = (op_in == OP_SLLM) ? MEM_WAIT : LOAD;
               end
            end
         end
         MEM_WAIT: begin
            // A late mem_ready on the final wait cycle still wins over timeout.
            if (mem_ready) begin
               state_next = LOAD;
               cnt_next   = '0;
            end else if (cnt_inc == WAIT_LIMIT) begin
               state_next   = IDLE;
               cnt_next     = '0;
               timeout_next = 1'b1;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         LOAD:    state_next = SHIFT;
         SHIFT:   state_next = WRITE;
         WRITE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      dec_amt = 2'b01;
      dec_src = 1'b0;
      dec_cmd = 3'b010;
      case (op_q)
         OP_SRL:  dec_cmd = 3'b011;
         OP_SRA:  dec_cmd = 3'b100;
         OP_SLLV: begin dec_amt = 2'b00; dec_src = 1'b1; end
         OP_SRAV: begin dec_amt = 2'b00; dec_src = 1'b1; dec_cmd = 3'b100; end
         OP_SLLM: dec_amt = 2'b10;
         default: ;
      endcase
   end

   always_comb begin
      Shift_Amt  = 2'b00;
      Shift_Src  = 1'b0;
      Shift_Ctrl = 3'b000;
      mem_read   = 1'b0;
      Reg_Wr     = 1'b0;
      done       = 1'b0;
      busy       = (state != IDLE);
      illegal    = illegal_q;
      timeout    = timeout_q;
      case (state)
         MEM_WAIT: begin
            mem_read  = 1'b1;
            Shift_Amt = 2'b10;
         end
         LOAD: begin
            Shift_Amt  = dec_amt;
            Shift_Src  = dec_src;
            Shift_Ctrl = 3'b001;
         end
         SHIFT: begin
            Shift_Amt  = dec_amt;
            Shift_Src  = dec_src;
            Shift_Ctrl = dec_cmd;
         end
         WRITE: begin
            Shift_Amt = dec_amt;
            Shift_Src = dec_src;
            Reg_Wr    = 1'b1;
            done      = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a transaction-level model predicts the
// per-cycle output bundle; a monitor compares tagged expectations at negedge.
module tb_shift_sequencer;

   localparam int MEM_TIMEOUT = 15;

   typedef struct packed {
      logic [1:0] amt;
      logic       src;
      logic [2:0] ctrl;
      logic       mem_read;
      logic       reg_wr;
      logic       busy;
      logic       done;
      logic       illegal;
      logic       timeout;
   } out_t;

   typedef struct {
      int    cyc;
      out_t  v;
      string ph;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, start, mem_ready;
   logic [2:0] Shift_Op;
   logic [1:0] Shift_Amt;
   logic       Shift_Src, mem_read, Reg_Wr, busy, done, illegal, timeout;
   logic [2:0] Shift_Ctrl;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   out_t act;

   shift_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .Shift_Op(Shift_Op),
      .mem_ready(mem_ready), .Shift_Amt(Shift_Amt), .Shift_Src(Shift_Src),
      .Shift_Ctrl(Shift_Ctrl), .mem_read(mem_read), .Reg_Wr(Reg_Wr),
      .busy(busy), .done(done), .illegal(illegal), .timeout(timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Operation tables straight from the instruction definitions.
   function automatic logic [1:0] amt_of(input logic [2:0] op);
      case (op)
         3'd3, 3'd4: return 2'b00;
         3'd5:       return 2'b10;
         default:    return 2'b01;
      endcase
   endfunction

   function automatic logic [2:0] cmd_of(input logic [2:0] op);
      case (op)
         3'd1:       return 3'b011;
         3'd2, 3'd4: return 3'b100;
         default:    return 3'b010;
      endcase
   endfunction

   function automatic out_t phase_out(input string ph, input logic [2:0] op);
      out_t o = '0;
      if (ph == "wait") begin
         o.amt = 2'b10; o.mem_read = 1'b1; o.busy = 1'b1;
      end else if (ph == "load" || ph == "shift" || ph == "write") begin
         o.amt  = amt_of(op);
         o.src  = (op == 3'd3 || op == 3'd4);
         o.busy = 1'b1;
         if (ph == "load")  o.ctrl = 3'b001;
         if (ph == "shift") o.ctrl = cmd_of(op);
         if (ph == "write") begin o.reg_wr = 1'b1; o.done = 1'b1; end
      end else if (ph == "illegal") begin
         o.illegal = 1'b1;
      end else if (ph == "timeout") begin
         o.timeout = 1'b1;
      end
      return o;
   endfunction

   task automatic push(input int c, input string ph, input logic [2:0] op, input int rst_edge);
      exp_t e;
      if (rst_edge > 0 && c >= rst_edge) return;
      e.cyc = c; e.v = phase_out(ph, op); e.ph = ph;
      exp_q.push_back(e);
   endtask

   // Issue one start window from IDLE. hold: edges start stays high;
   // ready_at: MEM_WAIT cycle (1-based) carrying mem_ready, 0 = never;
   // rst_off: edge offset from the first start edge carrying reset, 0 = none.
   task automatic do_seq(input logic [2:0] op, input int hold, input int ready_at, input int rst_off);
      int s = cyc + 1;
      int t = s;
      int w, rdy_edge, rst_edge, end_edge;
      bit sllm = (op == 3'd5);
      rst_edge = (rst_off > 0) ? s + rst_off : 0;
      rdy_edge = (sllm && ready_at >= 1 && ready_at <= MEM_TIMEOUT) ? s + ready_at : -1;
      while (t < s + hold) begin
         if (op[2:1] == 2'b11) begin
            push(t, "illegal", op, rst_edge);
            t = t + 1;
         end else if (sllm) begin
            w = (rdy_edge > 0) ? ready_at : MEM_TIMEOUT;
            for (int i = 0; i < w; i++) push(t + i, "wait", op, rst_edge);
            if (rdy_edge > 0) begin
               push(t + w, "load", op, rst_edge);
               push(t + w + 1, "shift", op, rst_edge);
               push(t + w + 2, "write", op, rst_edge);
               push(t + w + 3, "idle", op, rst_edge);
               t = t + w + 4;
            end else begin
               push(t + w, "timeout", op, rst_edge);
               t = t + w + 1;
            end
         end else begin
            push(t, "load", op, rst_edge);
            push(t + 1, "shift", op, rst_edge);
            push(t + 2, "write", op, rst_edge);
            push(t + 3, "idle", op, rst_edge);
            t = t + 4;
         end
      end
      push(t, "idle", op, rst_edge);
      if (rst_edge > 0) push(rst_edge, "post_reset", op, 0);
      end_edge = (rst_edge > 0) ? rst_edge : t;
      for (int e = s; e <= end_edge; e++) begin
         start     = (e < s + hold);
         Shift_Op  = start ? op : 3'($urandom);
         mem_ready = sllm ? (e == rdy_edge) : 1'($urandom);
         reset     = (rst_edge > 0 && e == rst_edge);
         @(posedge clk); #1;
      end
      start = 1'b0; mem_ready = 1'b0; reset = 1'b0;
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         mon_e = exp_q.pop_front();
         act   = {Shift_Amt, Shift_Src, Shift_Ctrl, mem_read, Reg_Wr, busy, done, illegal, timeout};
         checks = checks + 1;
         if (mon_e.cyc != cyc) begin
            errors = errors + 1;
            $display("FAIL %s missed: expected for cycle %0d, seen at cycle %0d", mon_e.ph, mon_e.cyc, cyc);
         end else if (act !== mon_e.v) begin
            errors = errors + 1;
            $display("FAIL %s @cycle %0d: got %03h expected %03h", mon_e.ph, cyc, act, mon_e.v);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int op, hold, rdy, roff;
      reset = 1'b1; start = 1'b1; Shift_Op = 3'd3; mem_ready = 1'b1;
      push(1, "reset", 3'd0, 0);
      push(2, "reset", 3'd0, 0);
      push(3, "reset_idle", 3'd0, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0; start = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;

      do_seq(3'd2, 1, 0, 0);    // SRA
      do_seq(3'd3, 5, 0, 0);    // SLLV, start held through WRITE and the IDLE after
      do_seq(3'd5, 1, 3, 0);    // SLLM, ready on wait cycle 3
      do_seq(3'd5, 1, 0, 0);    // SLLM, never ready -> timeout
      do_seq(3'd5, 1, 15, 0);   // SLLM, ready on the last wait cycle
      do_seq(3'd7, 1, 0, 0);    // illegal
      do_seq(3'd6, 2, 0, 0);    // illegal, held two edges
      do_seq(3'd1, 1, 0, 2);    // SRL, reset during SHIFT
      do_seq(3'd0, 1, 0, 0);    // SLL runs normally after reset
      do_seq(3'd4, 1, 0, 3);    // SRAV, reset during WRITE
      do_seq(3'd5, 1, 0, 5);    // SLLM, reset mid-wait

      for (int n = 0; n < 60; n++) begin
         op   = int'($urandom_range(0, 7));
         rdy  = int'($urandom_range(0, 17));
         hold = (op == 5) ? 1 : int'($urandom_range(1, 6));
         roff = 0;
         if ($urandom_range(0, 7) == 0) begin
            hold = 1;
            roff = int'($urandom_range(1, 8));
         end
         do_seq(3'(op), hold, rdy, roff);
         repeat ($urandom_range(0, 2)) begin
            Shift_Op = 3'($urandom); mem_ready = 1'($urandom);
            @(posedge clk); #1;
         end
         mem_ready = 1'b0;
      end

      for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors = errors + 1;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
